// File: rtl/dadda_final_cpa.sv
// dadda_final_cpa: multi-cycle chunked carry-propagate adder resolving Dadda sum/carry rows.
// Define DADDA_CPA_COUT_EN to expose the final carry on out_cout.
module dadda_final_cpa #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_row,
    input  logic [WIDTH-1:0] carry_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef DADDA_CPA_COUT_EN
    ,
    output logic             out_cout
`endif
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [CHUNK:0]   add_d;

    assign add_d = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q};
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_sum   = sum_q;

`ifdef DADDA_CPA_COUT_EN
    logic cout_q;
    assign out_cout = cout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef DADDA_CPA_COUT_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= sum_row;
                    b_q     <= carry_row;
                    cnt_q   <= '0;
                    carry_q <= 1'b0;
`ifdef DADDA_CPA_COUT_EN
                    cout_q  <= 1'b0;
`endif
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q[cnt_q*CHUNK +: CHUNK] <= add_d[CHUNK-1:0];
                    carry_q <= add_d[CHUNK];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NCH - 1)) begin
                        state_q <= DONE;
`ifdef DADDA_CPA_COUT_EN
                        cout_q  <= add_d[CHUNK];
`endif
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dadda_final_cpa.sv
// tb_dadda_final_cpa: directed self-checking bench for the chunked final adder.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_dadda_final_cpa;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] sum_row, carry_row, out_sum;
`ifdef DADDA_CPA_COUT_EN
    logic        out_cout;
`endif
    int n_asrt = 0;
    int n_fail = 0;

    dadda_final_cpa dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum_row(sum_row), .carry_row(carry_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum)
`ifdef DADDA_CPA_COUT_EN
        , .out_cout(out_cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum_row = '0; carry_row = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // carry from chunk 1 into chunk 2
        sum_row = 64'h0000_0000_FFFF_FFFF; carry_row = 64'h1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_busy_in_ready", 64'(in_ready), 64'd0);
        chk("t1_busy_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        chk("t1_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_sum", out_sum, 64'h0000_0001_0000_0000);

        // backpressure with a new pair waiting
        sum_row = 64'hFFFF_FFFF_FFFF_FFFF; carry_row = 64'h1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_sum", out_sum, 64'h0000_0001_0000_0000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        chk("hs_out_valid", 64'(out_valid), 64'd0);
        chk("hs_out_sum_held", out_sum, 64'h0000_0001_0000_0000);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_accepted", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("t2_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_out_sum", out_sum, 64'd0);
`ifdef DADDA_CPA_COUT_EN
        chk("t2_out_cout", 64'(out_cout), 64'd1);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // asynchronous reset in the second ADD cycle
        sum_row = 64'h1111_1111_1111_1111; carry_row = 64'h2222_2222_2222_2222; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_sum", out_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sum_row = 64'h1234_5678_9ABC_DEF0; carry_row = 64'h0FED_CBA9_8765_4321; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_no_early_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_out_sum", out_sum, 64'h2222_2222_2222_2211);
        out_ready = 1'b1;
        @(negedge clk);

        // back-to-back with in_valid and out_ready held high
        sum_row = 64'h0123_4567_89AB_CDEF; carry_row = 64'h1111_1111_1111_1111; in_valid = 1'b1;
        @(negedge clk);
        chk("b1_accepted", 64'(in_ready), 64'd0);
        sum_row = 64'h8000_0000_0000_0000; carry_row = 64'h8000_0000_0000_0001;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("b1_out_valid", 64'(out_valid), 64'd1);
        chk("b1_out_sum", out_sum, 64'h1234_5678_9ABC_DF00);
        @(negedge clk);
        chk("b2_idle_gap", 64'(in_ready), 64'd1);
        chk("b2_gap_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("b2_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("b2_out_valid", 64'(out_valid), 64'd1);
        chk("b2_out_sum", out_sum, 64'h0000_0000_0000_0001);
`ifdef DADDA_CPA_COUT_EN
        chk("b2_out_cout", 64'(out_cout), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/dadda_final_cpa.md
# dadda_final_cpa

Sequential carry-propagate adder that closes the 32x32 Dadda multiplier datapath. It sits directly downstream of the compression tree and its parallel adder stage. It takes the final two 64-bit rows (sum row and carry row) and resolves them into the 64-bit product by adding CHUNK-bit slices over successive cycles with a registered carry. A valid/ready handshake sits on both sides, so the multiplier can feed it without a full-width 64-bit ripple path in a single cycle.

## Interface
- WIDTH, 64: operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 16: bits added per cycle; NCH = WIDTH/CHUNK slices.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all state immediately and independently of clk.
- in_valid  input  1  the sum_row/carry_row pair is presented.
- in_ready  output  1  the block can accept an operand pair; high only in IDLE.
- sum_row  input  WIDTH  sum row from the compression stage.
- carry_row  input  WIDTH  carry row from the compression stage, already aligned; no internal shift.
- out_valid  output  1  out_sum holds the final product.
- out_ready  input  1  the consumer takes the result.
- out_sum  output  WIDTH  result register.
- out_cout  output  1  final carry out; present only with DADDA_CPA_COUT_EN.

## Operation
- States: IDLE, ADD, DONE. Chunk counter cnt is ceil(log2(NCH)) bits wide. The block holds a carry flop plus operand registers a_q and b_q.
- IDLE: in_ready=1. On in_valid & in_ready, the block captures sum_row→a_q and carry_row→b_q, clears cnt and the carry, and moves to ADD.
- ADD: each cycle computes {c, s} = a_q[cnt*CHUNK +: CHUNK] + b_q[cnt*CHUNK +: CHUNK] + carry.
  - s is written to out_sum[cnt*CHUNK +: CHUNK] and carry takes c.
  - cnt increments; when cnt == NCH-1, the state moves to DONE.
- DONE: out_valid=1. On out_ready the state moves to IDLE. out_sum is held until the next accepted transaction writes it.
- Arithmetic: the result is (sum_row + carry_row) mod 2^WIDTH. The final carry is discarded unless DADDA_CPA_COUT_EN is defined.
- Inputs are ignored outside IDLE. in_valid in ADD or DONE is not a transaction; upstream must hold its data until in_ready is high.
- Simultaneous events in DONE: out_ready high with in_valid high gives only the output handshake. The new input is accepted on the following IDLE cycle.
- Reset mid-operation: rst_n low in any state forces IDLE at once.
  - State is IDLE, in_ready=1 once rst_n is high, out_valid=0, out_sum=0, out_cout=0, carry=0, cnt=0.
  - The partial result is lost and no output handshake occurs.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, state IDLE.
- Latency: with the accepting edge called E0, chunk k is written at edge E(k+1). out_valid goes high after edge E(NCH), i.e. 4 cycles for the defaults.
- Minimum issue interval: NCH+2 cycles (6 for the defaults): accept, NCH add cycles, a DONE handshake cycle, then back in IDLE.
- out_sum and out_cout are stable throughout DONE. The bits of out_sum change only during ADD.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- DADDA_CPA_COUT_EN defined:
  - Port out_cout exists. It is loaded with the carry out of the last chunk at edge E(NCH) and held through DONE.
  - It is cleared at the next acceptance and on reset.
- DADDA_CPA_COUT_EN undefined:
  - The port and its flop are absent.
  - The final carry is dropped, and the result is modulo 2^WIDTH.

## Test plan
- Reset: assert rst_n low mid-simulation → in_ready=1, out_valid=0, out_sum=0 immediately, without waiting for a clock edge.
- sum_row=0x0000_0000_FFFF_FFFF, carry_row=0x1 → out_valid 4 cycles after acceptance, out_sum=0x0000_0001_0000_0000; checks carry across chunks 1→2.
- sum_row=0xFFFF_FFFF_FFFF_FFFF, carry_row=0x1 → out_sum=0. With DADDA_CPA_COUT_EN, out_cout=1; without it, no port exists.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new data → out_sum stable and in_ready=0 throughout. The second pair is accepted only after the output handshake plus one IDLE cycle.
- Reset in the second ADD cycle, then issue 0x1234_5678_9ABC_DEF0 + 0x0FED_CBA9_8765_4321 → no out_valid before the new transaction; result 0x2222_2222_2222_2211.
- Back-to-back: two transactions with out_ready=1 and in_valid=1 continuously → acceptances 6 cycles apart, both sums correct.
